ripple_count_capture: RTL
=========================

# ripple_count_capture

Synchronous capture stage placed directly downstream of the 3-bit asynchronous ripple up-counter. It brings the counter's ripple outputs into the `clk` domain and rejects ripple transients with a stability filter. Each settled change is converted into a modulo-8 increment event with valid/ready handshake, and the increments are accumulated into a wide extended count. It is the only sanctioned path for ripple-counter state to enter synchronous logic.

## Interface
Parameters:
- `SYNC_STAGES`, 2: depth of the synchronizer flop chain, minimum 2.
- `STABLE_CYCLES`, 3: consecutive identical synchronized samples required before a value is accepted, minimum 1, maximum 15.
- `EXT_WIDTH`, 16: width of the extended count.

Ports:
- `clk`, in, 1: single rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cnt_in`, in, 3: ripple-counter Q outputs, asynchronous to `clk`.
- `ext_count`, out, EXT_WIDTH: sum of all accepted deltas, modulo 2^EXT_WIDTH.
- `locked`, out, 1: a baseline value has been acquired.
- `evt_valid`, out, 1: an increment event is pending.
- `evt_delta`, out, 3: increment in counts, 1..7.
- `evt_wrap`, out, 1: the increment crossed 7→0.
- `evt_ready`, in, 1: the consumer accepts the event.
- `overflow`, out, 1: sticky flag, set when an event was dropped.
- `clr_overflow`, in, 1: synchronous clear of `overflow`.

## Operation
- **Reset values:** all outputs are 0. Synchronizer flops, candidate, run counter and accepted value are also 0. The FSM starts in ACQUIRE.
- **Synchronizer:** `cnt_in` passes through `SYNC_STAGES` flops to produce `sync_q`. There is no logic between the stages.
- **Filter:** each edge, if `sync_q == cand`, then `run` increments, saturating at `STABLE_CYCLES`. Otherwise `cand <= sync_q` and `run <= 1`.
- **Stable condition:** `stable = (run >= STABLE_CYCLES) && (cand != acc || state == ACQUIRE)`.
- **FSM ACQUIRE:** on `stable`, `acc <= cand`, `locked <= 1`, and the FSM moves to TRACK. No event is generated and `ext_count` is unchanged.
- **FSM TRACK:** on `stable`, compute `d = (cand - acc) mod 8`, which is 3-bit unsigned wrap and never 0. Then `acc <= cand` and `ext_count <= ext_count + d`, zero-extended, with wrap. The event carries `evt_delta = d` and `evt_wrap = (cand < acc)`.
- **There is no path back from TRACK to ACQUIRE except reset.**
- **Handshake:** the event transfers on a cycle with `evt_valid && evt_ready`. While `evt_valid` is high, `evt_delta` and `evt_wrap` hold steady.
- **New accept while an event is pending:**
  - If `evt_ready` is high the same cycle, the old event completes and the new one loads. `evt_valid` stays 1 and there is no overflow.
  - If `evt_ready` is low, the new event is dropped, `overflow` is set, and the pending event is unchanged. `ext_count` still updates.
- **`overflow`:** if set and `clr_overflow` occur in the same cycle, set wins.
- **Transients:** a value that persists in `sync_q` for fewer than `STABLE_CYCLES` edges is never accepted.
- **Reset mid-operation:** all state clears immediately and any pending event is discarded. Reacquisition follows the ACQUIRE rules.

## Timing
- Edge numbering: the rising edge that first samples a new, thereafter constant, `cnt_in` is edge 0.
- `sync_q` shows the new value after edge `SYNC_STAGES-1`.
- `cand`/`run=1` load at edge `SYNC_STAGES`.
- `acc`, `ext_count`, `evt_*` and `locked` update at edge `SYNC_STAGES+STABLE_CYCLES`. With the defaults this is edge 5.
- Event throughput is at most one per `STABLE_CYCLES` edges. Inputs must not advance more than 7 counts per acceptance window; faster input aliases and is not detected.
- All outputs are registered, with no combinational path from `evt_ready` or `cnt_in` to any output.

## Structure
- Package `ripple_cap_pkg` holds:
  - the state encoding: ACQUIRE=1'b0, TRACK=1'b1;
  - `CNT_W=3`;
  - the `mod8_delta` function.
- Sub-module `sync_bus` (parameters `WIDTH`, `STAGES`) is a pure flop chain with async active-low reset. It is the only instance of `cnt_in` sampling.
- The filter, FSM, accumulator and event register live in the top module.

## Test plan
- **Baseline acquire:** reset, then hold `cnt_in=3'b111` → `locked=1` at edge 5, `evt_valid=0`, `ext_count=0`.
- **Single step and wrap:** after lock on 7, set `cnt_in=0` → at edge 5, `evt_valid=1`, `evt_delta=1`, `evt_wrap=1`, `ext_count=1`. Then step to 3 with `evt_ready=1` → `evt_delta=3`, `evt_wrap=0`, `ext_count=4`.
- **Ripple glitch rejection:** from 3, drive 2 for 1 cycle, 0 for 1 cycle, then 4 steady → exactly one event with `evt_delta=1` and no event for 2 or 0.
- **Backpressure:** `evt_ready=0`, steps 0→2→5 → first event (`delta=2`) held, `overflow=1`, `ext_count=5`. Pulse `clr_overflow` → `overflow=0`. Then `evt_ready=1` → the held event transfers in one cycle.
- **Simultaneous ready and new accept:** pending event plus `evt_ready=1` on the acceptance edge → the new delta appears next, `overflow` stays 0.
- **Reset mid-event:** assert `rst_n=0` with `evt_valid=1` → all outputs 0 asynchronously. Release with `cnt_in=6` steady → relock on 6 with no event.

Source files
------------

// File: rtl/ripple_cap_pkg.sv
// Shared definitions for the ripple-counter capture stage: counter width,
// tracking FSM encoding and the modulo-8 increment helper.
package ripple_cap_pkg;

    localparam int CNT_W = 3;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } cap_state_t;

    // Forward distance from prev_val to now_val on the 3-bit ring. The
    // subtraction wraps naturally at the counter width.
    function automatic logic [CNT_W-1:0] mod8_delta(
        input logic [CNT_W-1:0] now_val,
        input logic [CNT_W-1:0] prev_val
    );
        return now_val - prev_val;
    endfunction

endpackage

// File: rtl/ripple_count_capture_sync_bus.sv
// Plain multi-flop synchronizer for a bus. It carries no logic between
// stages, so every stage can be placed as a synchronizer cell.
module sync_bus #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the asynchronous input through the flop chain, oldest sample on top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ripple_count_capture.sv
// Capture stage for the 3-bit asynchronous ripple counter. It synchronizes
// the counter outputs and filters out ripple transients. Settled changes
// become modulo-8 increment events with a valid/ready handshake, and a wide
// extended count accumulates every accepted increment.
module ripple_count_capture
    import ripple_cap_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3,
    parameter int EXT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_W-1:0]     cnt_in,
    output logic [EXT_WIDTH-1:0] ext_count,
    output logic                 locked,
    output logic                 evt_valid,
    output logic [CNT_W-1:0]     evt_delta,
    output logic                 evt_wrap,
    input  logic                 evt_ready,
    output logic                 overflow,
    input  logic                 clr_overflow
);

    // The run counter only has to reach STABLE_CYCLES, which is at most 15.
    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(STABLE_CYCLES);

    logic [CNT_W-1:0] sync_q;
    logic [CNT_W-1:0] cand;
    logic [RUN_W-1:0] run;
    logic [CNT_W-1:0] acc;
    cap_state_t       state;

    logic             stable;
    logic             accept_evt;
    logic [CNT_W-1:0] delta;
    logic             wrap;

    sync_bus #(
        .WIDTH (CNT_W),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (cnt_in),
        .q    (sync_q)
    );

    // Stability filter: count consecutive identical synchronized samples and
    // restart the count whenever the sample changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= '0;
            run  <= '0;
        end else if (sync_q == cand) begin
            if (run < RUN_TARGET) begin
                run <= run + RUN_W'(1);
            end
        end else begin
            cand <= sync_q;
            run  <= RUN_W'(1);
        end
    end

    // A value is accepted once it has settled. During ACQUIRE any settled
    // value is accepted, including one equal to the reset value of acc.
    assign stable     = (run >= RUN_TARGET) && ((cand != acc) || (state == ACQUIRE));
    assign accept_evt = stable && (state == TRACK);
    assign delta      = mod8_delta(cand, acc);
    assign wrap       = (cand < acc);

    // Tracking FSM with the accumulator, the event register and the sticky
    // overflow flag. A new event may replace a pending one only when the
    // pending one transfers on the same edge. Otherwise the new event is
    // dropped, but its increment still counts toward ext_count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACQUIRE;
            acc       <= '0;
            locked    <= 1'b0;
            ext_count <= '0;
            evt_valid <= 1'b0;
            evt_delta <= '0;
            evt_wrap  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ACQUIRE: begin
                    if (stable) begin
                        acc    <= cand;
                        locked <= 1'b1;
                        state  <= TRACK;
                    end
                end
                TRACK: begin
                    if (accept_evt) begin
                        acc       <= cand;
                        ext_count <= ext_count + EXT_WIDTH'(delta);
                    end
                end
                default: state <= ACQUIRE;
            endcase

            if (accept_evt && (!evt_valid || evt_ready)) begin
                evt_valid <= 1'b1;
                evt_delta <= delta;
                evt_wrap  <= wrap;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            if (accept_evt && evt_valid && !evt_ready) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
